// File: rtl/common.vh
// Shared helper macros for the arbiter slice.
`ifndef COMMON_VH
`define COMMON_VH

// Ceiling log2, used to size index and pointer fields.
`define CLOG2(x) $clog2(x)

`endif

// File: rtl/round_robin_priority_encoder.sv
// Combinational round-robin priority encoder.
// Finds the first set request at or after 'pointer', wrapping modulo REQUESTERS.
// It works for any requester count, including non-power-of-2 counts.
// The request vector is doubled and every position below the pointer is masked off.
// The lowest surviving bit is then the winner, and its position folds back into 0..REQUESTERS-1.
module round_robin_priority_encoder #(
  parameter int unsigned REQUESTERS      = 5,
  parameter int unsigned REQUESTERS_LOG2 = 3
) (
  input  logic [REQUESTERS-1:0]      requests,
  input  logic [REQUESTERS_LOG2-1:0] pointer,
  output logic                       found,
  output logic [REQUESTERS_LOG2-1:0] index,
  output logic [REQUESTERS-1:0]      one_hot
);

  // One extra bit so a position in the doubled vector (up to 2*REQUESTERS-1) fits.
  localparam int unsigned POS_W = REQUESTERS_LOG2 + 1;

  logic [2*REQUESTERS-1:0] doubled;
  logic [2*REQUESTERS-1:0] mask;
  logic [2*REQUESTERS-1:0] candidates;
  logic [POS_W-1:0]        first_pos;
  logic [POS_W-1:0]        folded_pos;

  // Keep only doubled positions at or above the pointer, so the search starts there and wraps.
  always_comb begin
    doubled = {requests, requests};
    mask    = '0;
    for (int i = 0; i < 2 * int'(REQUESTERS); i++) begin
      mask[i] = (i >= int'(pointer));
    end
    candidates = doubled & mask;
  end

  // Lowest set candidate bit; scanning downward lets the lowest hit overwrite higher ones.
  always_comb begin
    first_pos = '0;
    for (int i = 2 * int'(REQUESTERS) - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        first_pos = POS_W'(i);
      end
    end
  end

  // Fold the doubled position back into range and build the one-hot form.
  always_comb begin
    found = |candidates;
    if (first_pos >= POS_W'(REQUESTERS)) begin
      folded_pos = first_pos - POS_W'(REQUESTERS);
    end else begin
      folded_pos = first_pos;
    end
    index   = folded_pos[REQUESTERS_LOG2-1:0];
    one_hot = '0;
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      one_hot[i] = found && (int'(folded_pos) == i);
    end
  end

endmodule

// File: rtl/round_robin_grant_scheduler.sv
// Round-robin grant scheduler: shares one downstream resource between
// REQUESTERS requesters with a registered one-hot grant and a valid/ready handshake.
// The optional multi-beat lock input is enabled by defining ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN.
// In that build, a locked transfer re-issues the same grant while its request stays set.
`include "common.vh"

module round_robin_grant_scheduler #(
  parameter int unsigned REQUESTERS      = 5,
  parameter int unsigned REQUESTERS_LOG2 = `CLOG2(REQUESTERS),
  parameter int unsigned RESET_POINTER   = 0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [REQUESTERS-1:0]      requests,
  output logic [REQUESTERS-1:0]      grant,
  output logic [REQUESTERS_LOG2-1:0] grant_index,
  output logic                       grant_valid,
  input  logic                       grant_ready,
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
  input  logic                       grant_lock,
`endif
  output logic [REQUESTERS_LOG2-1:0] priority_pointer
);

  // Power-of-2 counts wrap naturally at the index width, so they can use a plain increment.
  localparam bit REQUESTERS_IS_POW2 = ((REQUESTERS & (REQUESTERS - 1)) == 0);
  localparam logic [REQUESTERS_LOG2-1:0] LAST_INDEX = REQUESTERS_LOG2'(REQUESTERS - 1);
  localparam logic [REQUESTERS_LOG2-1:0] ONE        = REQUESTERS_LOG2'(1);

  // Index that follows 'idx' in round-robin order.
  function automatic logic [REQUESTERS_LOG2-1:0] next_index(
    input logic [REQUESTERS_LOG2-1:0] idx
  );
    if (REQUESTERS_IS_POW2) begin
      return idx + ONE;
    end else if (idx == LAST_INDEX) begin
      return '0;
    end else begin
      return idx + ONE;
    end
  endfunction

  logic [REQUESTERS-1:0]      grant_q, grant_d;
  logic [REQUESTERS_LOG2-1:0] grant_index_q, grant_index_d;
  logic                       grant_valid_q, grant_valid_d;
  logic [REQUESTERS_LOG2-1:0] pointer_q, pointer_d;

  logic                       transfer;
  logic                       arbitrate;
  logic                       lock_hold;
  logic [REQUESTERS_LOG2-1:0] served_next;
  logic [REQUESTERS_LOG2-1:0] search_pointer;
  logic                       enc_found;
  logic [REQUESTERS_LOG2-1:0] enc_index;
  logic [REQUESTERS-1:0]      enc_one_hot;

  // Handshake decode. On a transfer the search already uses the advanced pointer, so grants can follow back to back.
  always_comb begin
    transfer       = grant_valid_q & grant_ready;
    arbitrate      = ~grant_valid_q | transfer;
    served_next    = next_index(grant_index_q);
    search_pointer = transfer ? served_next : pointer_q;
`ifdef ROUND_ROBIN_GRANT_SCHEDULER_LOCK_EN
    lock_hold      = transfer & grant_lock & requests[grant_index_q];
`else
    lock_hold      = 1'b0;
`endif
  end

  round_robin_priority_encoder #(
    .REQUESTERS      (REQUESTERS),
    .REQUESTERS_LOG2 (REQUESTERS_LOG2)
  ) u_priority_encoder (
    .requests (requests),
    .pointer  (search_pointer),
    .found    (enc_found),
    .index    (enc_index),
    .one_hot  (enc_one_hot)
  );

  // Next-state logic: hold while granted and stalled, re-issue on a locked beat, otherwise arbitrate.
  always_comb begin
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    grant_valid_d = grant_valid_q;
    pointer_d     = pointer_q;
    if (lock_hold) begin
      grant_valid_d = 1'b1;
    end else if (arbitrate) begin
      if (transfer) begin
        pointer_d = served_next;
      end
      grant_valid_d = enc_found;
      grant_d       = enc_found ? enc_one_hot : '0;
      if (enc_found) begin
        grant_index_d = enc_index;
      end
    end
  end

  // Grant and pointer registers. Reset drops any grant at once, with no handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant_q       <= '0;
      grant_index_q <= '0;
      grant_valid_q <= 1'b0;
      pointer_q     <= REQUESTERS_LOG2'(RESET_POINTER);
    end else begin
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      grant_valid_q <= grant_valid_d;
      pointer_q     <= pointer_d;
    end
  end

  assign grant            = grant_q;
  assign grant_index      = grant_index_q;
  assign grant_valid      = grant_valid_q;
  assign priority_pointer = pointer_q;

endmodule
